// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared ALU mode codes and helpers
//
// Purpose: operation codes shared by alu_exec, its alu sub-module and the
// bench, plus a helper that tells defined codes from undefined ones.
package alu_exec_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_INC = 3'b010,
    ALU_DEC = 3'b011
  } alu_mode_e;

  function automatic logic mode_defined(input logic [MODE_W-1:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - request/operand/result bundle for alu_exec
//
// Purpose: groups the request side (req, mode, use_carry, bus_in, flags_clr)
// and the status/result side (busy, done, err, result, carry, zero, equal).
// Modports: master drives requests (bench), slave is the execution unit.
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int N = 8
);

  logic              req;
  logic [MODE_W-1:0] mode;
  logic              use_carry;
  logic [N-1:0]      bus_in;
  logic              flags_clr;
  logic              busy;
  logic              done;
  logic              err;
  logic [N-1:0]      result;
  logic              carry;
  logic              zero;
  logic              equal;

  modport master (
    output req, mode, use_carry, bus_in, flags_clr,
    input  busy, done, err, result, carry, zero, equal
  );

  modport slave (
    input  req, mode, use_carry, bus_in, flags_clr,
    output busy, done, err, result, carry, zero, equal
  );

endinterface

// File: rtl/alu_exec_alu.sv
// rtl/alu_exec_alu.sv - combinational N-bit arithmetic unit
//
// Purpose: computes an N+1-bit result for ADD/SUB/INC/DEC; bit N is the
// carry out, or the borrow for SUB/DEC (two's-complement wrap sets it).
// Ports: a, b operands; mode op code; cin carry-in (ADD only);
//        y N-bit result; cout carry/borrow.
module alu
  import alu_exec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [MODE_W-1:0] mode,
  input  logic              cin,
  output logic [N-1:0]      y,
  output logic              cout
);

  logic [N:0] sum;

  always_comb begin
    sum = '0;
    case (mode)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      ALU_SUB: sum = {1'b0, a} - {1'b0, b};
      ALU_INC: sum = {1'b0, a} + {{N{1'b0}}, 1'b1};
      ALU_DEC: sum = {1'b0, a} - {{N{1'b0}}, 1'b1};
      default: sum = '0;
    endcase
  end

  assign y    = sum[N-1:0];
  assign cout = sum[N];

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - fixed-latency two-operand ALU execution unit
//
// Purpose: accepts a request with operand A, takes operand B on the next
// cycle, evaluates, and writes result and flags back with a done pulse three
// cycles after the request.
// Ports: clk, reset_n (async active-low); bus (alu_exec_if.slave) carries
//        req/mode/use_carry/bus_in/flags_clr in and busy/done/err/result/
//        carry/zero/equal out.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  alu_exec_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_B,
    S_EXEC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      opa_q, opa_d;
  logic [N-1:0]      opb_q, opb_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              use_carry_q, use_carry_d;
  logic [N-1:0]      result_q, result_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              equal_q, equal_d;

  logic [N-1:0]      alu_y;
  logic              alu_cout;
  logic              alu_cin;

  // Stored carry feeds the adder only for ADD requests that asked for it.
  assign alu_cin = carry_q & use_carry_q & (mode_q == ALU_ADD);

  alu #(.N(N)) u_alu (
    .a    (opa_q),
    .b    (opb_q),
    .mode (mode_q),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_cout)
  );

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    mode_d      = mode_q;
    use_carry_d = use_carry_q;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    equal_d     = equal_q;

    // Flag clear is ignored in DONE so the writeback always takes priority.
    if (bus.flags_clr && state_q != S_DONE) begin
      carry_d = 1'b0;
      zero_d  = 1'b0;
      equal_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          opa_d       = bus.bus_in;
          mode_d      = bus.mode;
          use_carry_d = bus.use_carry;
          state_d     = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        opb_d   = bus.bus_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // Operands are stable since EXEC, so the ALU output is unchanged here.
        if (mode_defined(mode_q)) begin
          result_d = alu_y;
          carry_d  = alu_cout;
          zero_d   = (alu_y == '0);
          equal_d  = (opa_q == opb_q);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      mode_q      <= '0;
      use_carry_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      equal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      mode_q      <= mode_d;
      use_carry_q <= use_carry_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      equal_q     <= equal_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = (state_q == S_DONE) & ~mode_defined(mode_q);
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.equal  = equal_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - self-checking bench for alu_exec
module tb_alu_exec;
  import alu_exec_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;

  alu_exec_if #(.N(N)) bus ();

  alu_exec #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   mode;
    logic         uc;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    logic         c;
    logic         z;
    logic         e;
    logic         err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  vec_t exp_q [$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Call just after a falling edge; returns just after the falling edge
  // that follows acceptance, with operand B on the bus.
  task automatic issue(input vec_t v);
    bus.req       = 1'b1;
    bus.mode      = v.mode;
    bus.use_carry = v.uc;
    bus.bus_in    = v.a;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    bus.req    = 1'b0;
    bus.bus_in = v.b;
  endtask

  task automatic collect(input string tag);
    int   n;
    vec_t v;
    n = 0;
    while (!bus.done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_latency"}, n, 2);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      v = exp_q.pop_front();
      check({tag, "_err"}, {31'd0, bus.err}, {31'd0, v.err});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_result"}, {24'd0, bus.result}, {24'd0, v.res});
      check({tag, "_carry"}, {31'd0, bus.carry}, {31'd0, v.c});
      check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, v.z});
      check({tag, "_equal"}, {31'd0, bus.equal}, {31'd0, v.e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   d;

    //            mode     uc    a      b      res    c     z     e     err
    vecs[0]  = '{ALU_ADD, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{ALU_ADD, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{ALU_ADD, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{ALU_SUB, 1'b0, 8'h7A, 8'h7A, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{ALU_SUB, 1'b0, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ALU_INC, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{ALU_DEC, 1'b0, 8'h00, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{ALU_ADD, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b111,  1'b0, 8'h12, 8'h12, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{ALU_INC, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{ALU_SUB, 1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_DEC, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{3'b100,  1'b0, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{ALU_ADD, 1'b1, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};

    reset_n       = 1'b0;
    bus.req       = 1'b0;
    bus.mode      = '0;
    bus.use_carry = 1'b0;
    bus.bus_in    = '0;
    bus.flags_clr = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_result", {24'd0, bus.result}, 32'd0);
    check("rst_flags", {29'd0, bus.carry, bus.zero, bus.equal}, 32'd0);
    check("rst_status", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);

    // First request rides the first rising edge after release.
    reset_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i]);
      collect($sformatf("vec%0d", i));
    end

    // flags_clr while idle clears flags but keeps the result.
    bus.flags_clr = 1'b1;
    @(negedge clk);
    bus.flags_clr = 1'b0;
    check("clr_idle_flags", {29'd0, bus.carry, bus.zero, bus.equal}, 32'd0);
    check("clr_idle_result", {24'd0, bus.result}, 32'h03);

    // flags_clr held through the whole operation: the writeback wins.
    v = '{ALU_ADD, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    issue(v);
    bus.flags_clr = 1'b1;
    collect("clr_done");
    bus.flags_clr = 1'b0;
    @(negedge clk);
    check("hold_flags", {29'd0, bus.carry, bus.zero, bus.equal}, 32'b110);

    // req held high while busy must not start a second operation.
    bus.req       = 1'b1;
    bus.mode      = ALU_ADD;
    bus.use_carry = 1'b0;
    bus.bus_in    = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.mode   = ALU_SUB;
    bus.bus_in = 8'h05;
    d = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d += int'(bus.done);
      bus.bus_in = 8'hAA;
    end
    bus.req = 1'b0;
    check("busy_req_result", {24'd0, bus.result}, 32'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d += int'(bus.done);
    end
    check("busy_req_one_done", d, 1);
    check("busy_req_idle", {31'd0, bus.busy}, 32'd0);

    // Leave nonzero result and carry so the reset clear is visible.
    v = '{ALU_DEC, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    issue(v);
    collect("pre_rst");

    // Reset in EXEC abandons the operation.
    bus.req    = 1'b1;
    bus.mode   = ALU_ADD;
    bus.bus_in = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.req    = 1'b0;
    bus.bus_in = 8'h01;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_result", {24'd0, bus.result}, 32'd0);
    check("mid_rst_flags", {29'd0, bus.carry, bus.zero, bus.equal}, 32'd0);
    check("mid_rst_status", {29'd0, bus.busy, bus.done, bus.err}, 32'd0);
    d = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d += int'(bus.done);
    end
    check("mid_rst_no_done", d, 0);
    reset_n = 1'b1;
    v = '{ALU_ADD, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
    issue(v);
    collect("post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
